// File: rtl/sample_ringbuf.sv
//==============================================================================
// sample_ringbuf : circular capture buffer with oldest-first AXI-stream replay
// Build option   : RINGBUF_STOP_ON_FULL_EN (linear fill, stop at full)
// Revision       : 1.0
//==============================================================================
`default_nettype none

module sample_ringbuf #(
  parameter int size    = 32,
  parameter int saddr_w = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [size-1:0]    s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [size-1:0]    m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  input  logic               start,
  input  logic               stop,
  input  logic               abort,
  output logic [saddr_w:0]   fill_count,
  output logic               wrapped,
  output logic               busy,
  output logic               done
);

  localparam int               c_depth = 1 << saddr_w;
  localparam logic [saddr_w:0] c_full  = {1'b1, {saddr_w{1'b0}}};
  localparam logic [saddr_w:0] c_one   = {{saddr_w{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT} state_t;

  state_t               state_q, state_d;
  logic [saddr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [saddr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [saddr_w:0]     fill_q, fill_d;
  logic [saddr_w:0]     rem_q, rem_d;
  logic                 wrapped_q, wrapped_d;
  logic                 done_q, done_d;

  logic [size-1:0]      mem [c_depth];
  logic [size-1:0]      ram_q;
  logic                 rv_q, rl_q;
  logic [size-1:0]      md_q, sd_q;
  logic                 mv_q, ml_q, sv_q, sl_q;

  logic                 w_full_stop;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_pop;
  logic                 w_flush;
  logic [1:0]           w_occ;

`ifdef RINGBUF_STOP_ON_FULL_EN
  assign w_full_stop = (fill_q == c_full);
`else
  assign w_full_stop = 1'b0;
`endif

  assign s_tready   = (state_q == S_CAPTURE) && !w_full_stop;
  assign w_wr_en    = s_tvalid && s_tready;
  assign w_pop      = mv_q && m_tready;

  // Reads are issued only when the output and skid registers can absorb the
  // word that returns one cycle later, so back-pressure never drops a sample.
  assign w_occ      = {1'b0, mv_q} + {1'b0, sv_q} + {1'b0, rv_q};
  assign w_rd_en    = (state_q == S_READOUT) && (rem_q != '0) && !abort &&
                      (w_pop ? (w_occ <= 2'd2) : (w_occ <= 2'd1));

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;
    done_d    = 1'b0;
    w_flush   = 1'b0;

    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != c_full) fill_d = fill_q + 1'b1;
`ifndef RINGBUF_STOP_ON_FULL_EN
      if (&wr_ptr_q) wrapped_d = 1'b1;
`endif
    end

    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rem_d    = rem_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CAPTURE;
          wr_ptr_d  = '0;
          fill_d    = '0;
          wrapped_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (stop) begin
          if (fill_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_READOUT;
            rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
            rem_d    = fill_d;
          end
        end
      end
      S_READOUT: begin
        if (w_pop && ml_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      w_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      rem_q     <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      rem_q     <= rem_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) mem[wr_ptr_q] <= s_tdata;
    if (w_rd_en) ram_q <= mem[rd_ptr_q];
  end

  // RAM word -> output register, or parked in the skid register while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_q <= 1'b0;
      rl_q <= 1'b0;
      mv_q <= 1'b0;
      md_q <= '0;
      ml_q <= 1'b0;
      sv_q <= 1'b0;
      sd_q <= '0;
      sl_q <= 1'b0;
    end else if (w_flush) begin
      rv_q <= 1'b0;
      mv_q <= 1'b0;
      ml_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      rv_q <= w_rd_en;
      rl_q <= w_rd_en && (rem_q == c_one);
      if (!mv_q || w_pop) begin
        if (sv_q) begin
          mv_q <= 1'b1;
          md_q <= sd_q;
          ml_q <= sl_q;
          sv_q <= rv_q;
          sd_q <= ram_q;
          sl_q <= rl_q;
        end else if (rv_q) begin
          mv_q <= 1'b1;
          md_q <= ram_q;
          ml_q <= rl_q;
        end else begin
          mv_q <= 1'b0;
          ml_q <= 1'b0;
        end
      end else if (rv_q) begin
        sv_q <= 1'b1;
        sd_q <= ram_q;
        sl_q <= rl_q;
      end
    end
  end

  assign m_tdata    = md_q;
  assign m_tvalid   = mv_q;
  assign m_tlast    = ml_q;
  assign fill_count = fill_q;
  assign wrapped    = wrapped_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

`default_nettype wire
